lcd_spi_write: RTL and testbench



---
 rtl/lcd_pkg.sv | 23 ++
 rtl/lcd_spi_write.sv | 170 +++++++++++++++++
 tb/tb_lcd_spi_write.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD serial write path.
package lcd_pkg;

    localparam int unsigned LCD_WORD_W = 9;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4,
        GAP   = 3'd5
    } lcd_wr_state_e;

    // Cycles from the capture edge to the wr_done cycle.
    function automatic int unsigned frame_cycles(input int unsigned clk_div);
        return 1 + 18 * clk_div;
    endfunction

endpackage

// File: rtl/lcd_spi_write.sv
// Serial write engine: sends one {dc, byte} word as a mode-0, MSB-first SPI frame.
module lcd_spi_write
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                  sys_clk_50MHz,
    input  logic                  sys_rst_n,
    input  logic                  en_write,
    input  logic [LCD_WORD_W-1:0] data,
    output logic                  wr_done,
    output logic                  busy,
    output logic                  lcd_cs,
    output logic                  lcd_dc,
    output logic                  lcd_sck,
    output logic                  lcd_mosi
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int unsigned BIT_W = 3;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    lcd_wr_state_e    state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             cs_q, cs_d;
    logic             dc_q, dc_d;
    logic             sck_q, sck_d;
    logic             mosi_q, mosi_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    // State, counters, shift register and registered outputs.
    always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            gap_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            cs_q    <= 1'b1;
            dc_q    <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            gap_q   <= gap_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            cs_q    <= cs_d;
            dc_q    <= dc_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next state plus next output values; outputs are computed one cycle ahead.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        gap_d   = gap_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        cs_d    = cs_q;
        dc_d    = dc_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        unique case (state_q)
            IDLE: begin
                if (en_write) begin
                    state_d = SETUP;
                    shift_d = data[7:0];
                    dc_d    = data[8];
                    mosi_d  = data[7];
                    cs_d    = 1'b0;
                    sck_d   = 1'b0;
                    busy_d  = 1'b1;
                    div_d   = '0;
                end
            end

            SETUP: begin
                if (div_q == DIV_LAST) begin
                    state_d = SHIFT;
                    bit_d   = BIT_W'(7);
                    div_d   = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        // End of a high phase: next bit's data goes out with the falling edge.
                        sck_d = 1'b0;
                        if (bit_q == '0) begin
                            state_d = HOLD;
                        end else begin
                            bit_d  = bit_q - BIT_W'(1);
                            mosi_d = shift_q[bit_q - BIT_W'(1)];
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            HOLD: begin
                if (div_q == DIV_LAST) begin
                    state_d = DONE;
                    div_d   = '0;
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            DONE: begin
                state_d = GAP;
                gap_d   = '0;
            end

            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                    gap_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cs_d    = 1'b1;
                sck_d   = 1'b0;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign wr_done  = done_q;
    assign busy     = busy_q;
    assign lcd_cs   = cs_q;
    assign lcd_dc   = dc_q;
    assign lcd_sck  = sck_q;
    assign lcd_mosi = mosi_q;

endmodule

// File: tb/tb_lcd_spi_write.sv
// Bench for lcd_spi_write: two builds (CLK_DIV=2 and CLK_DIV=1) against a frame-timing model.
module tb_lcd_spi_write;
    import lcd_pkg::*;

    localparam int G = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en0 = 1'b0, en1 = 1'b0;
    logic [8:0] data0 = '0, data1 = '0;
    logic       done0, busy0, cs0, dc0, sck0, mosi0;
    logic       done1, busy1, cs1, dc1, sck1, mosi1;

    always #10 clk = ~clk;

    lcd_spi_write #(.CLK_DIV(2), .GAP_CYCLES(2)) u_dut0 (
        .sys_clk_50MHz(clk), .sys_rst_n(rst_n), .en_write(en0), .data(data0),
        .wr_done(done0), .busy(busy0), .lcd_cs(cs0), .lcd_dc(dc0),
        .lcd_sck(sck0), .lcd_mosi(mosi0)
    );

    lcd_spi_write #(.CLK_DIV(1), .GAP_CYCLES(2)) u_dut1 (
        .sys_clk_50MHz(clk), .sys_rst_n(rst_n), .en_write(en1), .data(data1),
        .wr_done(done1), .busy(busy1), .lcd_cs(cs1), .lcd_dc(dc1),
        .lcd_sck(sck1), .lcd_mosi(mosi1)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    bit         m_valid [2];
    int         m_c     [2];
    logic [8:0] m_w     [2];
    int         done_cnt [2];
    int         last_done[2];
    int         hi_run = 0;
    int         min_gap = 1000;

    logic [7:0] rx_sh   [2];
    int         rx_edges[2];
    int         rx_q0[$];
    int         rx_q1[$];

    logic [8:0] words [4];

    typedef struct packed {
        bit cs, sck, mosi_chk, mosi, dc_chk, dc, done, busy;
    } exp_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic bit model_idle(input int i, input int n);
        return !m_valid[i] || (n - m_c[i]) > int'(frame_cycles(div_of(i))) + G;
    endfunction

    // Expected outputs k cycles after the capture edge, from the frame timing rules.
    function automatic exp_t model_out(input int k, input logic [8:0] w, input int d);
        exp_t e;
        int   f, s;
        e = '0;
        e.cs = 1'b1;
        e.mosi_chk = 1'b1;
        f = 1 + 18 * d;
        if (k >= 1 && k <= 18 * d) begin
            e.cs = 1'b0;
            e.busy = 1'b1;
            e.dc_chk = 1'b1;
            e.dc = w[8];
            e.mosi_chk = 1'b0;
            if (k <= d) begin
                e.mosi_chk = 1'b1;
                e.mosi = w[7];
            end else begin
                s = k - 1 - d;
                if (s < 16 * d) begin
                    e.sck = (s % (2 * d)) >= d;
                    e.mosi_chk = 1'b1;
                    e.mosi = w[7 - s / (2 * d)];
                end
            end
        end else if (k >= f && k <= f + G) begin
            e.busy = 1'b1;
            e.done = (k == f);
        end
        return e;
    endfunction

    task automatic check_inst(input int i, input logic cs, input logic sck, input logic mosi,
                              input logic dc, input logic done, input logic busy);
        exp_t e;
        if (!rst_n) begin
            e = '0;
            e.cs = 1'b1;
            e.mosi_chk = 1'b1;
            e.dc_chk = 1'b1;
        end else if (m_valid[i]) begin
            e = model_out(cyc - m_c[i], m_w[i], div_of(i));
        end else begin
            e = '0;
            e.cs = 1'b1;
            e.mosi_chk = 1'b1;
        end
        check($sformatf("u%0d_cs", i), int'(cs), int'(e.cs));
        check($sformatf("u%0d_sck", i), int'(sck), int'(e.sck));
        check($sformatf("u%0d_wr_done", i), int'(done), int'(e.done));
        check($sformatf("u%0d_busy", i), int'(busy), int'(e.busy));
        if (e.mosi_chk) check($sformatf("u%0d_mosi", i), int'(mosi), int'(e.mosi));
        if (e.dc_chk) check($sformatf("u%0d_dc", i), int'(dc), int'(e.dc));
    endtask

    // Model update on the capture edge; cyc counts completed clock cycles.
    always @(posedge clk) begin
        int n;
        n = cyc;
        if (!rst_n) begin
            m_valid[0] = 1'b0;
            m_valid[1] = 1'b0;
        end else begin
            if (model_idle(0, n) && en0) begin
                m_valid[0] = 1'b1; m_c[0] = n; m_w[0] = data0;
            end
            if (model_idle(1, n) && en1) begin
                m_valid[1] = 1'b1; m_c[1] = n; m_w[1] = data1;
            end
        end
        cyc = n + 1;
    end

    // Per-cycle compare, wr_done bookkeeping and CS-high run tracking.
    always @(negedge clk) begin
        if (chk_en) begin
            if (rst_n && done0) begin done_cnt[0]++; last_done[0] = cyc; end
            if (rst_n && done1) begin done_cnt[1]++; last_done[1] = cyc; end
            if (rst_n) begin
                if (cs0) hi_run++;
                else begin
                    if (hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
                    hi_run = 0;
                end
            end
            check_inst(0, cs0, sck0, mosi0, dc0, done0, busy0);
            check_inst(1, cs1, sck1, mosi1, dc1, done1, busy1);
        end
    end

    // Panel-side receivers: sample MOSI on each SCK rising edge while CS is low.
    always @(negedge cs0) begin rx_sh[0] = '0; rx_edges[0] = 0; end
    always @(posedge sck0) if (!cs0) begin rx_sh[0] = {rx_sh[0][6:0], mosi0}; rx_edges[0]++; end
    always @(posedge cs0) if (rst_n) rx_q0.push_back((rx_edges[0] << 9) | int'({dc0, rx_sh[0]}));
    always @(negedge cs1) begin rx_sh[1] = '0; rx_edges[1] = 0; end
    always @(posedge sck1) if (!cs1) begin rx_sh[1] = {rx_sh[1][6:0], mosi1}; rx_edges[1]++; end
    always @(posedge cs1) if (rst_n) rx_q1.push_back((rx_edges[1] << 9) | int'({dc1, rx_sh[1]}));

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic wait_done(input int i, input int from_cnt, input int budget, output int at);
        at = -1;
        for (int t = 0; t < budget; t++) begin
            tick();
            if (done_cnt[i] > from_cnt) begin
                at = last_done[i];
                break;
            end
        end
        check($sformatf("u%0d_done_seen", i), int'(at >= 0), 1);
    endtask

    task automatic check_rx0(input string name, input logic [8:0] w);
        check({name, "_rx_present"}, int'(rx_q0.size() > 0), 1);
        if (rx_q0.size() > 0) check({name, "_rx"}, rx_q0.pop_front(), (8 << 9) | int'(w));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int c, at, base;
        words[0] = 9'h0CF; words[1] = 9'h100; words[2] = 9'h1C9; words[3] = 9'h130;
        done_cnt[0] = 0; done_cnt[1] = 0;

        // Reset with en_write high: outputs must sit at reset values.
        #3 rst_n = 1'b0;
        en0 = 1'b1;
        data0 = 9'h0CF;
        chk_en = 1'b1;
        repeat (3) tick();
        check("rst_cs", int'(cs0), 1);
        check("rst_sck", int'(sck0), 0);
        check("rst_mosi", int'(mosi0), 0);
        check("rst_dc", int'(dc0), 0);
        check("rst_wr_done", int'(done0), 0);
        check("rst_busy", int'(busy0), 0);

        // Command word captured on the first clock after release.
        rst_n = 1'b1;
        c = cyc;
        tick();
        en0 = 1'b0;
        check("cmd_cs_low_c1", int'(cs0), 0);
        check("cmd_busy_c1", int'(busy0), 1);
        wait_done(0, done_cnt[0], 60, at);
        check("cmd_done_cycle", at - c, 37);
        check_rx0("cmd", 9'h0CF);

        // Data word.
        repeat (4) tick();
        base = done_cnt[0];
        en0 = 1'b1; data0 = 9'h1A5; c = cyc;
        tick();
        en0 = 1'b0;
        wait_done(0, base, 60, at);
        check("data_done_cycle", at - c, 37);
        check_rx0("data", 9'h1A5);
        repeat (6) tick();
        check("data_done_count", done_cnt[0] - base, 1);

        // Back-to-back stream driven by an init-sequencer-like source.
        min_gap = 1000;
        base = done_cnt[0];
        data0 = words[0]; en0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_done(0, base + i, 60, at);
            tick();
            if (i < 3) data0 = words[i + 1];
            else en0 = 1'b0;
        end
        repeat (8) tick();
        check("stream_done_count", done_cnt[0] - base, 4);
        check("stream_cs_gap", min_gap, 4);
        for (int i = 0; i < 4; i++) check_rx0($sformatf("stream%0d", i), words[i]);

        // en_write dropped and data changed during bit 5: original byte completes.
        base = done_cnt[0];
        en0 = 1'b1; data0 = 9'h15A; c = cyc;
        run_to(c + 12);
        en0 = 1'b0; data0 = 9'h0AA;
        wait_done(0, base, 60, at);
        check("abort_en_done_cycle", at - c, 37);
        repeat (10) tick();
        check("abort_en_done_count", done_cnt[0] - base, 1);
        check("abort_en_idle_busy", int'(busy0), 0);
        check_rx0("abort_en", 9'h15A);

        // Reset during bit 4: immediate return to idle values, no wr_done.
        base = done_cnt[0];
        en0 = 1'b1; data0 = 9'h0F0; c = cyc;
        tick();
        en0 = 1'b0;
        run_to(c + 16);
        check("pre_rst_cs", int'(cs0), 0);
        rst_n = 1'b0;
        #1;
        check("abort_rst_cs", int'(cs0), 1);
        check("abort_rst_sck", int'(sck0), 0);
        check("abort_rst_busy", int'(busy0), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("abort_rst_no_done", done_cnt[0] - base, 0);
        check("abort_rst_no_rx", rx_q0.size(), 0);
        en0 = 1'b1; data0 = 9'h033; c = cyc;
        tick();
        en0 = 1'b0;
        wait_done(0, base, 60, at);
        check("post_rst_done_cycle", at - c, 37);
        check_rx0("post_rst", 9'h033);

        // CLK_DIV=1 build: one-cycle SCK phases.
        repeat (4) tick();
        base = done_cnt[1];
        en1 = 1'b1; data1 = 9'h02C; c = cyc;
        tick();
        en1 = 1'b0;
        wait_done(1, base, 40, at);
        check("div1_done_cycle", at - c, 19);
        check("div1_rx_present", int'(rx_q1.size() > 0), 1);
        if (rx_q1.size() > 0) check("div1_rx", rx_q1.pop_front(), (8 << 9) | 'h02C);
        repeat (6) tick();
        check("div1_done_count", done_cnt[1] - base, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
